// File: rtl/mask_pair_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mask_pair_sequencer_pkg
// Description : Shared field offsets, widths, FSM encoding and popcount helper
//               for the mask pair sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mask_pair_sequencer_pkg;

    localparam int LANES    = 16;
    localparam int CNT_W    = 5;
    localparam int POS_W    = 4;

    localparam int W_LSB    = 0;
    localparam int A_LSB    = 16;
    localparam int NUMW_LSB = 32;
    localparam int NUMA_LSB = 40;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mask_pair_sequencer_lsb_enc.sv
`default_nettype none
// ============================================================================
// Module      : lowest_set_bit_encoder
// Description : Lowest-set-bit index, mask with that bit cleared, and a flag
//               that at most one bit is set.
// Revision    : 1.0 - initial release
// ============================================================================
module lowest_set_bit_encoder #(
    parameter int WIDTH = 16,
    parameter int POS_W = 4
) (
    input  logic [WIDTH-1:0] mask,
    output logic [POS_W-1:0] idx,
    output logic [WIDTH-1:0] cleared,
    output logic             le_one
);

    always_comb begin
        idx = '0;
        // Scan downwards so the lowest set bit wins.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = POS_W'(i);
            end
        end
    end

    assign cleared = mask & (mask - WIDTH'(1));
    assign le_one  = (cleared == '0);

endmodule
`default_nettype wire

// File: rtl/mask_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mask_pair_sequencer
// Description : Serialises the mutual non-zero W/A lane pairs of a matcher
//               result word into one (wIndex, aIndex) beat per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mask_pair_sequencer
    import mask_pair_sequencer_pkg::*;
#(
    parameter int BITMASK_LENGTH = 16,
    parameter int INDEX_BITWIDTH = 5,
    parameter int POS_BITWIDTH   = 4
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      ivalid,
    output logic                      oready,
    input  logic [63:0]               result,
    output logic                      ovalid,
    input  logic                      iready,
    output logic                      pairValid,
    output logic [POS_BITWIDTH-1:0]   wIndex,
    output logic [POS_BITWIDTH-1:0]   aIndex,
    output logic                      olast,
    output logic [INDEX_BITWIDTH-1:0] numW,
    output logic [INDEX_BITWIDTH-1:0] numA,
    output logic                      error
);

    state_t                    r_state, w_state_nxt;
    logic [BITMASK_LENGTH-1:0] r_regw, r_rega, w_regw_nxt, w_rega_nxt;
    logic [INDEX_BITWIDTH-1:0] r_numw, r_numa, w_numw_nxt, w_numa_nxt;
    logic                      r_error, w_error_nxt;

    logic [BITMASK_LENGTH-1:0] w_in_w, w_in_a, w_clr_w, w_clr_a;
    logic [POS_BITWIDTH-1:0]   w_idx_w, w_idx_a;
    logic                      w_le1_w, w_le1_a;
    logic                      w_accept, w_xfer, w_mismatch;
    logic                      w_unused;

    assign w_in_w     = result[W_LSB +: BITMASK_LENGTH];
    assign w_in_a     = result[A_LSB +: BITMASK_LENGTH];
    assign w_mismatch = popcount16(16'(w_in_w)) != popcount16(16'(w_in_a));
    assign w_unused   = ^result;

    lowest_set_bit_encoder #(.WIDTH(BITMASK_LENGTH), .POS_W(POS_BITWIDTH)) u_enc_w (
        .mask(r_regw), .idx(w_idx_w), .cleared(w_clr_w), .le_one(w_le1_w)
    );

    lowest_set_bit_encoder #(.WIDTH(BITMASK_LENGTH), .POS_W(POS_BITWIDTH)) u_enc_a (
        .mask(r_rega), .idx(w_idx_a), .cleared(w_clr_a), .le_one(w_le1_a)
    );

    assign ovalid    = (r_state == S_EMIT);
    assign pairValid = ovalid && (r_regw != '0) && (r_rega != '0);
    assign olast     = ovalid && (w_le1_w || w_le1_a);
    assign wIndex    = w_idx_w;
    assign aIndex    = w_idx_a;
    assign numW      = r_numw;
    assign numA      = r_numa;
    assign error     = r_error;

    // Combinational iready->oready lets the next block start with no bubble.
    assign oready   = resetn && ((r_state == S_IDLE) || (olast && iready));
    assign w_accept = ivalid && oready;
    assign w_xfer   = ovalid && iready;

    always_comb begin
        w_state_nxt = r_state;
        w_regw_nxt  = r_regw;
        w_rega_nxt  = r_rega;
        w_numw_nxt  = r_numw;
        w_numa_nxt  = r_numa;
        w_error_nxt = r_error || (w_accept && w_mismatch);
        if (w_accept) begin
            w_state_nxt = S_EMIT;
            w_regw_nxt  = w_in_w;
            w_rega_nxt  = w_in_a;
            w_numw_nxt  = result[NUMW_LSB +: INDEX_BITWIDTH];
            w_numa_nxt  = result[NUMA_LSB +: INDEX_BITWIDTH];
        end else if (w_xfer) begin
            if (olast) begin
                w_state_nxt = S_IDLE;
                w_regw_nxt  = '0;
                w_rega_nxt  = '0;
            end else begin
                w_regw_nxt  = w_clr_w;
                w_rega_nxt  = w_clr_a;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_regw  <= '0;
            r_rega  <= '0;
            r_numw  <= '0;
            r_numa  <= '0;
            r_error <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_regw  <= w_regw_nxt;
            r_rega  <= w_rega_nxt;
            r_numw  <= w_numw_nxt;
            r_numa  <= w_numa_nxt;
            r_error <= w_error_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mask_pair_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mask_pair_sequencer
// Description : Directed self-checking bench for mask_pair_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_pair_sequencer;

    logic        clock = 1'b0;
    logic        resetn, ivalid, iready;
    logic [63:0] result;
    logic        oready, ovalid, pairValid, olast, error;
    logic [3:0]  wIndex, aIndex;
    logic [4:0]  numW, numA;

    int total = 0;
    int bad   = 0;
    int xfers = 0;

    localparam logic [63:0] V1 = 64'h0000_0304_0003_0005;
    localparam logic [63:0] V2 = 64'h0000_0002_0000_0000;
    localparam logic [63:0] V3 = 64'h0000_1010_FFFF_FFFF;
    localparam logic [63:0] V5 = 64'h0000_0101_0001_0001;
    localparam logic [63:0] V6 = 64'h0000_0202_0001_0003;

    always #5 clock = ~clock;

    mask_pair_sequencer dut (
        .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready),
        .result(result), .ovalid(ovalid), .iready(iready),
        .pairValid(pairValid), .wIndex(wIndex), .aIndex(aIndex),
        .olast(olast), .numW(numW), .numA(numA), .error(error)
    );

    always @(negedge clock) begin
        if (ovalid && iready) xfers <= xfers + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic beat(input string tag, input logic pv, input logic [3:0] w,
                        input logic [3:0] a, input logic last);
        chk({tag, "_ovalid"}, 32'(ovalid), 32'd1);
        chk({tag, "_pv"},     32'(pairValid), 32'(pv));
        chk({tag, "_w"},      32'(wIndex), 32'(w));
        chk({tag, "_a"},      32'(aIndex), 32'(a));
        chk({tag, "_last"},   32'(olast), 32'(last));
    endtask

    initial begin
        resetn = 1'b0; ivalid = 1'b0; iready = 1'b1; result = '0;
        tick();
        #3;
        chk("rst_ovalid", 32'(ovalid), 0);
        chk("rst_oready", 32'(oready), 0);
        chk("rst_error",  32'(error), 0);
        chk("rst_numW",   32'(numW), 0);
        chk("rst_numA",   32'(numA), 0);
        chk("rst_pv",     32'(pairValid), 0);
        chk("rst_last",   32'(olast), 0);
        chk("rst_w",      32'(wIndex), 0);

        // Basic two-pair block
        resetn = 1'b1; ivalid = 1'b1; result = V1;
        #3; chk("t1_oready", 32'(oready), 1);
        tick(); ivalid = 1'b0;
        #3; beat("t1_b0", 1, 0, 0, 0);
        chk("t1_numW", 32'(numW), 4);
        chk("t1_numA", 32'(numA), 3);
        tick();
        #3; beat("t1_b1", 1, 2, 1, 1);
        tick();
        #3; chk("t1_idle", 32'(ovalid), 0);
        chk("t1_error", 32'(error), 0);

        // Empty block
        ivalid = 1'b1; result = V2;
        tick(); ivalid = 1'b0;
        #3; beat("t2_b0", 0, 0, 0, 1);
        chk("t2_numW", 32'(numW), 2);
        chk("t2_numA", 32'(numA), 0);
        tick();
        #3; chk("t2_oready", 32'(oready), 1);
        chk("t2_idle", 32'(ovalid), 0);

        // Full 16-pair block
        ivalid = 1'b1; result = V3;
        tick(); ivalid = 1'b0;
        #3; chk("t3_numW", 32'(numW), 16);
        chk("t3_numA", 32'(numA), 16);
        for (int k = 0; k < 16; k++) begin
            beat($sformatf("t3_k%0d", k), 1, 4'(k), 4'(k), k == 15);
            tick();
            #3;
        end
        chk("t3_idle", 32'(ovalid), 0);

        // Back-pressure on the last beat
        xfers = 0;
        ivalid = 1'b1; result = V1;
        tick(); ivalid = 1'b0;
        #3; beat("t4_b0", 1, 0, 0, 0);
        tick(); iready = 1'b0;
        #3; beat("t4_s0", 1, 2, 1, 1);
        chk("t4_oready_stall", 32'(oready), 0);
        tick();
        #3; beat("t4_s1", 1, 2, 1, 1);
        tick(); iready = 1'b1;
        #3; beat("t4_s2", 1, 2, 1, 1);
        tick();
        #3; chk("t4_idle", 32'(ovalid), 0);
        chk("t4_xfers", 32'(xfers), 2);

        // Back-to-back blocks, ivalid held high
        ivalid = 1'b1; result = V1;
        tick(); result = V5;
        #3; beat("t5_b0", 1, 0, 0, 0);
        chk("t5_oready0", 32'(oready), 0);
        tick();
        #3; beat("t5_b1", 1, 2, 1, 1);
        chk("t5_oready1", 32'(oready), 1);
        tick(); ivalid = 1'b0;
        #3; beat("t5_n0", 1, 0, 0, 1);
        chk("t5_numW", 32'(numW), 1);
        chk("t5_numA", 32'(numA), 1);
        tick();
        #3; chk("t5_idle", 32'(ovalid), 0);
        chk("t5_error", 32'(error), 0);

        // Popcount mismatch
        ivalid = 1'b1; result = V6;
        tick(); ivalid = 1'b0;
        #3; beat("t6_b0", 1, 0, 0, 1);
        chk("t6_error", 32'(error), 1);
        tick();
        #3; chk("t6_idle", 32'(ovalid), 0);
        chk("t6_sticky", 32'(error), 1);

        // Reset in the middle of a block
        ivalid = 1'b1; result = V3;
        tick(); ivalid = 1'b0;
        tick();
        tick();
        #3; beat("t7_k2", 1, 2, 2, 0);
        resetn = 1'b0;
        tick();
        #3; chk("t7_ovalid", 32'(ovalid), 0);
        chk("t7_error", 32'(error), 0);
        chk("t7_oready_rst", 32'(oready), 0);
        chk("t7_numW", 32'(numW), 0);
        resetn = 1'b1;
        #1; chk("t7_oready", 32'(oready), 1);
        tick();
        #3; chk("t7_still_idle", 32'(ovalid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mask_pair_sequencer.md
Name: mask_pair_sequencer

Overview:
- Downstream stage of the 16-lane mask matcher.
- Accepts one 64-bit matcher result word per block: the packed W mask, the packed A mask and the W/A operand counts.
- Serialises the mutual non-zero pairs into one (wIndex, aIndex) pair per cycle. Each index addresses the compressed W or A operand buffer feeding the MAC.
- Closes every block with a last beat that carries the buffer pop counts.

Parameters:
- BITMASK_LENGTH, 16, lanes per block; legal range 2..16.
- INDEX_BITWIDTH, 5, width of count fields; must hold BITMASK_LENGTH.
- POS_BITWIDTH, 4, width of emitted buffer indices; equals clog2(BITMASK_LENGTH).

Ports:
- clock  in  1  single clock; all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- ivalid  in  1  result word valid.
- oready  out  1  block can accept a result word.
- result  in  64  matcher word:
  - [15:0] packed W mask
  - [31:16] packed A mask
  - [36:32] numW
  - [44:40] numA
  - other bits ignored.
- ovalid  out  1  output beat valid.
- iready  in  1  downstream accepts beat.
- pairValid  out  1  beat carries a real pair; 0 only on the empty-block beat.
- wIndex  out  POS_BITWIDTH  index into compressed W buffer.
- aIndex  out  POS_BITWIDTH  index into compressed A buffer.
- olast  out  1  final beat of block.
- numW  out  INDEX_BITWIDTH  W buffer pop count, held for the whole block.
- numA  out  INDEX_BITWIDTH  A buffer pop count, held for the whole block.
- error  out  1  sticky: packed W and A popcounts differed in some block.

Behaviour:
- Reset: one clock with resetn low, applied synchronously.
  - ovalid=0, pairValid=0, olast=0, error=0, numW=numA=0, wIndex=aIndex=0; state=IDLE.
  - oready=0 while resetn low.
- Reset mid-block discards the block; no further beats are issued.
- FSM states: IDLE, EMIT.
- IDLE:
  - oready=1.
  - On ivalid, load regW, regA, numW and numA, then go to EMIT.
- EMIT:
  - ovalid=1.
  - wIndex = position of the lowest set bit of regW; aIndex = same for regA.
  - pairValid = (regW!=0) && (regA!=0).
  - olast=1 when the current beat is the only remaining one: popcount ≤1 in regW or in regA, or either register is 0.
- Handshake and advance:
  - A beat transfers when ovalid && iready; beat outputs stay stable while iready=0.
  - On transfer with olast=0, clear the lowest set bit of both regW and regA.
  - On transfer with olast=1, return to IDLE, unless a new word is accepted in the same cycle, in which case reload and stay in EMIT.
- Back-to-back blocks:
  - oready = (state==IDLE) || (ovalid && olast && iready), giving zero bubbles between blocks.
  - This is a combinational iready→oready path.
- Latency: first beat appears the cycle after acceptance; a block with P pairs needs max(P,1) beats.
- Empty block (packed W or A all zero):
  - Exactly one beat with pairValid=0, olast=1, and numW/numA as loaded, so the buffers still pop.
- Popcount mismatch:
  - Emit min(popW, popA) pairs; error is set on acceptance of the offending word.
  - error stays set until reset.
- Count fields are passed through unchecked; a count of 16 must be representable.

Decomposition:
- Shared package holds:
  - result field offsets: W_LSB=0, A_LSB=16, NUMW_LSB=32, NUMA_LSB=40
  - FSM state encoding
  - lane and width constants.
- One sub-module: lowest_set_bit_encoder, combinational priority encoder producing:
  - lowest-set-bit index
  - the mask with that bit cleared
  - a "≤1 bit set" flag.
- Two instances are used, one for regW and one for regA.

Test Plan:
- result=0x0000_0304_0003_0005, iready=1:
  - beat0 w=0 a=0 pairValid=1 olast=0; beat1 w=2 a=1 olast=1; numW=4 numA=3; error=0.
- result=0x0000_0002_0000_0000:
  - single beat pairValid=0 olast=1 numW=2 numA=0; oready high again next cycle.
- result=0x0000_1010_FFFF_FFFF:
  - 16 beats w=a=k for k=0..15; olast only on k=15; numW=numA=16.
- First vector with iready toggling 1,0,0,1:
  - beat1 outputs held stable across stalls; exactly 2 transfers.
- Two words streamed with ivalid constant (first vector then 0x0000_0101_0001_0001):
  - second word accepted on the first block's last transfer; no idle cycle; then one beat w=0 a=0 olast=1.
- result=0x0000_0202_0001_0003 (popcount mismatch):
  - one beat w=0 a=0 olast=1; error=1 and sticky.
- resetn low mid-block of the 16-pair vector:
  - next cycle ovalid=0, error=0, state IDLE, oready=1 after release.
